// File: rtl/edge_detect_sync_multi_if.sv
// Channel bundle for edge_detect_sync_multi: raw inputs, per-channel mode and
// sticky-clear controls in; stretched pulses, sticky flags and armed status out.
interface edge_detect_sync_multi_if #(
    parameter int N_CH = 8
);
    logic [N_CH-1:0]   in;
    logic [2*N_CH-1:0] mode;
    logic [N_CH-1:0]   clr_seen;
    logic [N_CH-1:0]   out;
    logic [N_CH-1:0]   edge_seen;
    logic              armed;

    modport master (
        output in, mode, clr_seen,
        input  out, edge_seen, armed
    );

    modport slave (
        input  in, mode, clr_seen,
        output out, edge_seen, armed
    );
endinterface

// File: rtl/edge_detect_sync_multi.sv
// Multi-channel edge detector: synchroniser, optional debounce, per-channel
// rise/fall/both selection, retriggerable pulse stretcher and sticky event flag.
module edge_detect_sync_multi #(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 0,
    parameter int STRETCH     = 2
) (
    input logic                     sync_clk,
    input logic                     reset,
    edge_detect_sync_multi_if.slave bus
);
    localparam int              FMAX       = (FILTER > 1) ? FILTER : 1;
    localparam int              FW         = (FILTER > 1) ? $clog2(FILTER + 1) : 1;
    localparam logic [FW-1:0]   FCNT_TOP   = FW'(FMAX - 1);
    // Last count value before armed sets: SYNC_STAGES + FMAX + 1 cycles in total.
    localparam logic [8:0]      ARM_TOP    = 9'(SYNC_STAGES + FMAX);
    localparam logic [7:0]      STRETCH_LD = 8'(STRETCH);

    logic [N_CH-1:0][SYNC_STAGES-1:0] sync_r;
    logic [N_CH-1:0]                  f_r;
    logic [N_CH-1:0]                  fd_r;
    logic [N_CH-1:0][FW-1:0]          fcnt_r;
    logic [N_CH-1:0][7:0]             scnt_r;
    logic [N_CH-1:0]                  out_r;
    logic [N_CH-1:0]                  seen_r;
    logic [8:0]                       arm_cnt_r;
    logic                             armed_r;

    logic [N_CH-1:0]                  s_s;
    logic [N_CH-1:0]                  rise_s;
    logic [N_CH-1:0]                  fall_s;
    logic [N_CH-1:0]                  event_s;
    logic [N_CH-1:0][7:0]             scnt_nxt_s;
    logic [N_CH-1:0]                  seen_nxt_s;

    // Synchroniser chains, one per channel.
    always_ff @(posedge sync_clk or posedge reset) begin
        if (reset) begin
            sync_r <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], bus.in[i]};
            end
        end
    end

    // Startup settling counter; armed stays set until the next reset.
    always_ff @(posedge sync_clk or posedge reset) begin
        if (reset) begin
            arm_cnt_r <= 9'd0;
            armed_r   <= 1'b0;
        end else if (!armed_r) begin
            if (arm_cnt_r == ARM_TOP) begin
                armed_r <= 1'b1;
            end else begin
                arm_cnt_r <= arm_cnt_r + 9'd1;
            end
        end
    end

    // Debounce filter; before armed the filter tracks the synchroniser directly.
    always_ff @(posedge sync_clk or posedge reset) begin
        if (reset) begin
            f_r    <= '0;
            fd_r   <= '0;
            fcnt_r <= '0;
        end else begin
            fd_r <= f_r;
            for (int i = 0; i < N_CH; i++) begin
                if (!armed_r) begin
                    f_r[i]    <= s_s[i];
                    fcnt_r[i] <= '0;
                end else if (s_s[i] == f_r[i]) begin
                    fcnt_r[i] <= '0;
                end else if (fcnt_r[i] == FCNT_TOP) begin
                    f_r[i]    <= s_s[i];
                    fcnt_r[i] <= '0;
                end else begin
                    fcnt_r[i] <= fcnt_r[i] + FW'(1);
                end
            end
        end
    end

    // Event qualification, stretch counter and sticky-flag next state.
    always_comb begin
        s_s        = '0;
        rise_s     = '0;
        fall_s     = '0;
        event_s    = '0;
        scnt_nxt_s = scnt_r;
        seen_nxt_s = seen_r;
        for (int i = 0; i < N_CH; i++) begin
            s_s[i]     = sync_r[i][SYNC_STAGES-1];
            rise_s[i]  = f_r[i] & ~fd_r[i];
            fall_s[i]  = ~f_r[i] & fd_r[i];
            event_s[i] = armed_r & ((bus.mode[2*i] & rise_s[i]) | (bus.mode[2*i+1] & fall_s[i]));
            if (event_s[i]) begin
                scnt_nxt_s[i] = STRETCH_LD;
            end else if (scnt_r[i] != 8'd0) begin
                scnt_nxt_s[i] = scnt_r[i] - 8'd1;
            end else begin
                scnt_nxt_s[i] = 8'd0;
            end
            // A new event outranks a coincident clear.
            if (event_s[i]) begin
                seen_nxt_s[i] = 1'b1;
            end else if (bus.clr_seen[i]) begin
                seen_nxt_s[i] = 1'b0;
            end else begin
                seen_nxt_s[i] = seen_r[i];
            end
        end
    end

    // Registered pulse outputs and sticky flags.
    always_ff @(posedge sync_clk or posedge reset) begin
        if (reset) begin
            scnt_r <= '0;
            out_r  <= '0;
            seen_r <= '0;
        end else begin
            scnt_r <= scnt_nxt_s;
            seen_r <= seen_nxt_s;
            for (int i = 0; i < N_CH; i++) begin
                out_r[i] <= (scnt_nxt_s[i] != 8'd0);
            end
        end
    end

    assign bus.out       = out_r;
    assign bus.edge_seen = seen_r;
    assign bus.armed     = armed_r;
endmodule
